hand_position_scheduler: RTL and testbench
==========================================

HAND_POSITION_SCHEDULER -- requirements
Module: hand_position_scheduler

Interface
REQ-001 Parameter STALE_FRAMES, default 8, is the number of frames without an update after which a hand is reported absent.
REQ-002 vclock  in  1  65 MHz pixel clock; the block has one clock, and all state changes on its rising edge.
REQ-003 reset_n  in  1  reset, synchronous and active-low.
REQ-004 vsync  in  1  XVGA vertical sync, active-low.
REQ-005 l_valid, r_valid  in  1 each  left/right tracker sample valid.
REQ-006 l_x, l_y, l_z, r_x, r_y, r_z  in  16 each  Kinect-space coordinates (x 0..399, y 0..599, z unscaled).
REQ-007 l_ready, r_ready  out  1 each  sample accepted this cycle.
REQ-008 x1_disp, x2_disp  out  11 each  screen x, left/right hand.
REQ-009 y1_disp, y2_disp  out  10 each  screen y.
REQ-010 z1_disp, z2_disp  out  16 each  committed z, passed through unscaled.
REQ-011 present1, present2  out  1 each  hand is fresh (not stale).
REQ-012 frame_commit  out  1  one-cycle pulse on every commit.

Function
REQ-013 Valid/ready handshake: a transfer occurs when valid=1 and ready=1 in the same cycle.
REQ-014 Valid handshake rules: once valid rises, the source holds valid and data stable until the transfer; ready never depends combinationally on valid.
REQ-015 FSM states are IDLE, ACCEPT, SCALE and WRITE.
REQ-016 IDLE: with any valid high, register the grant and go to ACCEPT; otherwise stay in IDLE.
REQ-017 ACCEPT: assert ready for the granted channel only, capture its x/y/z, and go to SCALE.
REQ-018 SCALE: clamp and scale, then go to WRITE.
REQ-019 WRITE: write the shadow registers of the granted hand, set that hand's updated flag, and go to IDLE.
REQ-020 Latency: ready asserts 2 cycles after valid is sampled in IDLE; shadow is written 2 cycles after ready; at most one transfer per 4 cycles.
REQ-021 Arbitration is round-robin: on simultaneous l_valid and r_valid, the channel not granted most recently wins; after reset, left has priority.
REQ-022 Clamping: x above 399 is treated as 399; y above 599 is treated as 599.
REQ-023 Scaling: x_disp = (x*41)>>4; y_disp = (y*41)>>5; truncate, do not round; products are computed at no less than 16 bits before the shift; max outputs are 1022 and 767.
REQ-024 Commit event: a registered copy of vsync is 1 while vsync is 0 (falling edge), detected in any FSM state.
REQ-025 On commit: copy both shadow sets to the *_disp outputs, pulse frame_commit for exactly 1 cycle, update the stale logic, and clear both updated flags.
REQ-026 Stale logic, per hand: if updated, the counter goes to 0; otherwise the counter increments, saturating at 15; present = (counter < STALE_FRAMES), registered at commit.
REQ-027 WRITE coinciding with commit: commit takes the pre-write shadow and the clears are applied first; the new write lands in the shadow and sets its updated flag, and takes effect at the next commit.
REQ-028 Outside commits, the *_disp, present and z outputs are stable for the whole frame (tear-free).
REQ-029 vsync held low does not cause repeated commits; exactly one commit occurs per falling edge.

Reset
REQ-030 While reset_n=0 at a clock edge: FSM to IDLE, l_ready=r_ready=0, frame_commit=0.
REQ-031 Reset values also include: all *_disp and shadows 0, present1=present2=0, stale counters 15, updated flags 0, round-robin priority to left, and the registered vsync copy set to 1.
REQ-032 Reset asserted mid-transaction aborts it: the captured sample is discarded and the source must re-present it.

Verification
REQ-033 Reset: hold reset_n=0 for 2 cycles -> all outputs 0, present 0; the first vsync fall with no samples gives frame_commit=1 and outputs still 0.
REQ-034 Single update: l_x=200, l_y=300, l_z=50 valid, then vsync fall -> x1_disp=512, y1_disp=384, z1_disp=50, present1=1, present2=0.
REQ-035 Contention and latency: after reset, both valid in the same cycle with r_x=300, r_y=500, r_z=100 -> l_ready pulses at cycle 2 and r_ready 4 cycles later; the next commit gives x2_disp=768, y2_disp=640, z2_disp=100.
REQ-036 Clamp: l_x=1000, l_y=700 -> after commit, x1_disp=1022, y1_disp=767.
REQ-037 Staleness: after present1=1, no left samples for 8 commits -> present1 falls exactly on the 8th commit, and x1_disp keeps its last value.
REQ-038 Collision and reset abort: WRITE in the same cycle as the vsync fall -> old value committed, new value on the next commit; reset_n=0 during SCALE -> no shadow change and FSM in IDLE.

Source files
------------

// File: rtl/hand_position_scheduler.sv
// ----------------------------------------------------------------------------
// hand_position_scheduler
//
// Accepts left/right hand samples from two trackers over valid/ready
// handshakes, clamps and scales Kinect-space coordinates to screen space,
// and holds them in per-hand shadow registers. On every falling edge of the
// XVGA vertical sync, both shadow sets are committed to the display outputs
// at once, so a frame never shows a half-updated hand position. A per-hand
// staleness counter reports a hand absent after STALE_FRAMES commits
// without a fresh sample.
//
// Ports
//   vclock           in   pixel clock; all state changes on its rising edge
//   reset_n          in   synchronous active-low reset
//   vsync            in   vertical sync, active-low
//   l_valid/r_valid  in   tracker sample valid (left/right)
//   l_x/l_y/l_z      in   left sample, 16 bits each
//   r_x/r_y/r_z      in   right sample, 16 bits each
//   l_ready/r_ready  out  sample accepted this cycle
//   x1_disp/x2_disp  out  11-bit screen x (left/right)
//   y1_disp/y2_disp  out  10-bit screen y (left/right)
//   z1_disp/z2_disp  out  16-bit committed z, unscaled
//   present1/2       out  hand is fresh
//   frame_commit     out  one-cycle pulse per commit
// ----------------------------------------------------------------------------
module hand_position_scheduler #(
   parameter int STALE_FRAMES = 8
) (
   input  logic        vclock,
   input  logic        reset_n,
   input  logic        vsync,
   input  logic        l_valid,
   input  logic        r_valid,
   input  logic [15:0] l_x,
   input  logic [15:0] l_y,
   input  logic [15:0] l_z,
   input  logic [15:0] r_x,
   input  logic [15:0] r_y,
   input  logic [15:0] r_z,
   output logic        l_ready,
   output logic        r_ready,
   output logic [10:0] x1_disp,
   output logic [10:0] x2_disp,
   output logic [9:0]  y1_disp,
   output logic [9:0]  y2_disp,
   output logic [15:0] z1_disp,
   output logic [15:0] z2_disp,
   output logic        present1,
   output logic        present2,
   output logic        frame_commit
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCEPT,
      ST_SCALE,
      ST_WRITE
   } state_t;

   localparam logic [3:0]  STALE_MAX = 4'd15;
   localparam logic [15:0] X_MAX     = 16'd399;
   localparam logic [15:0] Y_MAX     = 16'd599;

   state_t      r_state;
   state_t      w_state_next;

   // Channel being served (1 = right) and round-robin tie-break (1 = right wins).
   logic        r_grant_right;
   logic        r_prio_right;
   logic        w_grant_right_next;

   logic [15:0] r_cap_x;
   logic [15:0] r_cap_y;
   logic [15:0] r_cap_z;

   logic [10:0] r_scl_x;
   logic [9:0]  r_scl_y;
   logic [15:0] r_scl_z;

   logic [10:0] r_sh_x1;
   logic [9:0]  r_sh_y1;
   logic [15:0] r_sh_z1;
   logic [10:0] r_sh_x2;
   logic [9:0]  r_sh_y2;
   logic [15:0] r_sh_z2;

   logic [10:0] r_x1_disp;
   logic [9:0]  r_y1_disp;
   logic [15:0] r_z1_disp;
   logic [10:0] r_x2_disp;
   logic [9:0]  r_y2_disp;
   logic [15:0] r_z2_disp;

   logic        r_upd1;
   logic        r_upd2;
   logic [3:0]  r_stale1;
   logic [3:0]  r_stale2;
   logic        r_present1;
   logic        r_present2;

   logic        r_vsync_q;
   logic        r_frame_commit;
   logic        w_commit;

   logic        w_l_ready;
   logic        w_r_ready;

   logic [8:0]  w_x_clamped;
   logic [9:0]  w_y_clamped;
   logic [15:0] w_x_prod;
   logic [15:0] w_y_prod;
   logic [10:0] w_x_scaled;
   logic [9:0]  w_y_scaled;

   logic [3:0]  w_stale1_next;
   logic [3:0]  w_stale2_next;

   // -------------------------------------------------------------------------
   // Commit detection: previous vsync high, current vsync low. Holding vsync
   // low keeps r_vsync_q at 0, so only one commit fires per falling edge.
   // -------------------------------------------------------------------------
   assign w_commit = r_vsync_q & ~vsync;

   // On a tie the hand not granted most recently wins.
   assign w_grant_right_next = (l_valid && r_valid) ? r_prio_right : r_valid;

   // -------------------------------------------------------------------------
   // FSM state register
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process ordering.
   always_ff @(posedge vclock) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // -------------------------------------------------------------------------
   // FSM next state and ready outputs. Ready depends only on state and the
   // registered grant, never on valid.
   // -------------------------------------------------------------------------
   // NOTE: every signal gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      w_state_next = r_state;
      w_l_ready    = 1'b0;
      w_r_ready    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (l_valid || r_valid) begin
               w_state_next = ST_ACCEPT;
            end
         end
         ST_ACCEPT: begin
            w_l_ready    = ~r_grant_right;
            w_r_ready    = r_grant_right;
            w_state_next = ST_SCALE;
         end
         ST_SCALE: begin
            w_state_next = ST_WRITE;
         end
         ST_WRITE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Clamp and scale. The clamped values fit in 9/10 bits, so the 16-bit
   // products cannot overflow (399*41 = 16359, 599*41 = 24559).
   // -------------------------------------------------------------------------
   assign w_x_clamped = (r_cap_x > X_MAX) ? 9'd399  : r_cap_x[8:0];
   assign w_y_clamped = (r_cap_y > Y_MAX) ? 10'd599 : r_cap_y[9:0];
   assign w_x_prod    = {7'd0, w_x_clamped} * 16'd41;
   assign w_y_prod    = {6'd0, w_y_clamped} * 16'd41;
   assign w_x_scaled  = 11'(w_x_prod >> 4);
   assign w_y_scaled  = 10'(w_y_prod >> 5);

   // -------------------------------------------------------------------------
   // Staleness: a hand updated since the last commit restarts at 0, else the
   // count climbs and saturates.
   // -------------------------------------------------------------------------
   assign w_stale1_next = r_upd1 ? 4'd0 :
                          ((r_stale1 == STALE_MAX) ? STALE_MAX : r_stale1 + 4'd1);
   assign w_stale2_next = r_upd2 ? 4'd0 :
                          ((r_stale2 == STALE_MAX) ? STALE_MAX : r_stale2 + 4'd1);

   // -------------------------------------------------------------------------
   // Datapath, shadows and commit
   // -------------------------------------------------------------------------
   // NOTE: shadow and display registers are reset explicitly so the first
   // commit after reset shows zeros rather than stale pre-reset contents.
   always_ff @(posedge vclock) begin
      if (!reset_n) begin
         r_grant_right  <= 1'b0;
         r_prio_right   <= 1'b0;
         r_cap_x        <= '0;
         r_cap_y        <= '0;
         r_cap_z        <= '0;
         r_scl_x        <= '0;
         r_scl_y        <= '0;
         r_scl_z        <= '0;
         r_sh_x1        <= '0;
         r_sh_y1        <= '0;
         r_sh_z1        <= '0;
         r_sh_x2        <= '0;
         r_sh_y2        <= '0;
         r_sh_z2        <= '0;
         r_x1_disp      <= '0;
         r_y1_disp      <= '0;
         r_z1_disp      <= '0;
         r_x2_disp      <= '0;
         r_y2_disp      <= '0;
         r_z2_disp      <= '0;
         r_upd1         <= 1'b0;
         r_upd2         <= 1'b0;
         r_stale1       <= STALE_MAX;
         r_stale2       <= STALE_MAX;
         r_present1     <= 1'b0;
         r_present2     <= 1'b0;
         r_vsync_q      <= 1'b1;
         r_frame_commit <= 1'b0;
      end else begin
         r_vsync_q      <= vsync;
         r_frame_commit <= w_commit;

         if (r_state == ST_IDLE && (l_valid || r_valid)) begin
            r_grant_right <= w_grant_right_next;
            r_prio_right  <= ~w_grant_right_next;
         end

         if (r_state == ST_ACCEPT) begin
            r_cap_x <= r_grant_right ? r_x : l_x;
            r_cap_y <= r_grant_right ? r_y : l_y;
            r_cap_z <= r_grant_right ? r_z : l_z;
         end

         if (r_state == ST_SCALE) begin
            r_scl_x <= w_x_scaled;
            r_scl_y <= w_y_scaled;
            r_scl_z <= r_cap_z;
         end

         // Commit reads the pre-write shadow; its flag clears come first so a
         // coinciding WRITE below re-arms its hand for the next commit.
         if (w_commit) begin
            r_x1_disp  <= r_sh_x1;
            r_y1_disp  <= r_sh_y1;
            r_z1_disp  <= r_sh_z1;
            r_x2_disp  <= r_sh_x2;
            r_y2_disp  <= r_sh_y2;
            r_z2_disp  <= r_sh_z2;
            r_stale1   <= w_stale1_next;
            r_stale2   <= w_stale2_next;
            r_present1 <= (32'(w_stale1_next) < 32'(STALE_FRAMES));
            r_present2 <= (32'(w_stale2_next) < 32'(STALE_FRAMES));
            r_upd1     <= 1'b0;
            r_upd2     <= 1'b0;
         end

         if (r_state == ST_WRITE) begin
            if (r_grant_right) begin
               r_sh_x2 <= r_scl_x;
               r_sh_y2 <= r_scl_y;
               r_sh_z2 <= r_scl_z;
               r_upd2  <= 1'b1;
            end else begin
               r_sh_x1 <= r_scl_x;
               r_sh_y1 <= r_scl_y;
               r_sh_z1 <= r_scl_z;
               r_upd1  <= 1'b1;
            end
         end
      end
   end

   assign l_ready      = w_l_ready;
   assign r_ready      = w_r_ready;
   assign x1_disp      = r_x1_disp;
   assign y1_disp      = r_y1_disp;
   assign z1_disp      = r_z1_disp;
   assign x2_disp      = r_x2_disp;
   assign y2_disp      = r_y2_disp;
   assign z2_disp      = r_z2_disp;
   assign present1     = r_present1;
   assign present2     = r_present2;
   assign frame_commit = r_frame_commit;

endmodule

// File: tb/tb_hand_position_scheduler.sv
// ----------------------------------------------------------------------------
// Self-checking bench for hand_position_scheduler. A frame-level reference
// model (shadow per hand, committed copy, staleness count) predicts every
// output; directed steps cover reset, latency, arbitration, clamping,
// staleness, commit/write collision and reset abort, then random frames.
// ----------------------------------------------------------------------------
module tb_hand_position_scheduler;

   localparam int STALE = 8;

   logic        vclock = 1'b0;
   logic        reset_n;
   logic        vsync;
   logic        l_valid, r_valid;
   logic [15:0] l_x, l_y, l_z, r_x, r_y, r_z;
   logic        l_ready, r_ready;
   logic [10:0] x1_disp, x2_disp;
   logic [9:0]  y1_disp, y2_disp;
   logic [15:0] z1_disp, z2_disp;
   logic        present1, present2;
   logic        frame_commit;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   // Reference model, index 0 = left hand, 1 = right hand.
   int m_sh_x[2], m_sh_y[2], m_sh_z[2];
   int m_dx[2], m_dy[2], m_dz[2];
   int m_cnt[2];
   bit m_upd[2], m_pres[2];

   always #5 vclock = ~vclock;

   hand_position_scheduler #(.STALE_FRAMES(STALE)) dut (
      .vclock(vclock), .reset_n(reset_n), .vsync(vsync),
      .l_valid(l_valid), .r_valid(r_valid),
      .l_x(l_x), .l_y(l_y), .l_z(l_z), .r_x(r_x), .r_y(r_y), .r_z(r_z),
      .l_ready(l_ready), .r_ready(r_ready),
      .x1_disp(x1_disp), .x2_disp(x2_disp),
      .y1_disp(y1_disp), .y2_disp(y2_disp),
      .z1_disp(z1_disp), .z2_disp(z2_disp),
      .present1(present1), .present2(present2),
      .frame_commit(frame_commit)
   );

   function automatic int ref_x(int x);
      return ((x > 399) ? 399 : x) * 41 / 16;
   endfunction

   function automatic int ref_y(int y);
      return ((y > 599) ? 599 : y) * 41 / 32;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge vclock);
      #1;
   endtask

   task automatic model_reset();
      for (int h = 0; h < 2; h++) begin
         m_sh_x[h] = 0; m_sh_y[h] = 0; m_sh_z[h] = 0;
         m_dx[h] = 0;   m_dy[h] = 0;   m_dz[h] = 0;
         m_cnt[h] = 15; m_upd[h] = 0;  m_pres[h] = 0;
      end
   endtask

   task automatic model_write(input int h, input int x, input int y, input int z);
      m_sh_x[h] = ref_x(x);
      m_sh_y[h] = ref_y(y);
      m_sh_z[h] = z;
      m_upd[h]  = 1;
   endtask

   task automatic model_commit();
      for (int h = 0; h < 2; h++) begin
         m_dx[h] = m_sh_x[h]; m_dy[h] = m_sh_y[h]; m_dz[h] = m_sh_z[h];
         m_cnt[h]  = m_upd[h] ? 0 : ((m_cnt[h] >= 15) ? 15 : m_cnt[h] + 1);
         m_pres[h] = (m_cnt[h] < STALE);
         m_upd[h]  = 0;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".x1"}, 32'(x1_disp), m_dx[0]);
      check({tag, ".y1"}, 32'(y1_disp), m_dy[0]);
      check({tag, ".z1"}, 32'(z1_disp), m_dz[0]);
      check({tag, ".x2"}, 32'(x2_disp), m_dx[1]);
      check({tag, ".y2"}, 32'(y2_disp), m_dy[1]);
      check({tag, ".z2"}, 32'(z2_disp), m_dz[1]);
      check({tag, ".p1"}, 32'(present1), 32'(m_pres[0]));
      check({tag, ".p2"}, 32'(present2), 32'(m_pres[1]));
   endtask

   task automatic do_reset();
      reset_n = 1'b0; vsync = 1'b1; l_valid = 1'b0; r_valid = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      model_reset();
   endtask

   // vsync falling edge; vsync is then held low a cycle to show no repeat.
   task automatic commit(input string tag);
      vsync = 1'b0;
      tick();
      model_commit();
      check({tag, ".fc_hi"}, 32'(frame_commit), 1);
      check_all(tag);
      tick();
      check({tag, ".fc_lo"}, 32'(frame_commit), 0);
      check_all({tag, ".hold"});
      vsync = 1'b1;
      tick();
      tick();
   endtask

   // Single-channel transfer from an idle scheduler. With collide set, the
   // vsync fall is placed in the WRITE cycle of this transfer.
   task automatic send(input int h, input int x, input int y, input int z, input bit collide);
      bit got = 0;
      int lat = 0;
      if (h == 0) begin l_x = 16'(x); l_y = 16'(y); l_z = 16'(z); l_valid = 1'b1; end
      else        begin r_x = 16'(x); r_y = 16'(y); r_z = 16'(z); r_valid = 1'b1; end
      for (int c = 1; c <= 8 && !got; c++) begin
         @(negedge vclock);
         if ((h == 0) ? l_ready : r_ready) begin
            got = 1;
            lat = c;
         end
         tick();
      end
      l_valid = 1'b0;
      r_valid = 1'b0;
      check("send.ready_cycle", lat, 2);
      if (got) begin
         if (collide) begin
            tick();
            vsync = 1'b0;
            tick();
            model_commit();
            model_write(h, x, y, z);
            check("collide.fc_hi", 32'(frame_commit), 1);
            check_all("collide");
            tick();
            check("collide.fc_lo", 32'(frame_commit), 0);
            vsync = 1'b1;
            tick();
         end else begin
            tick();
            tick();
            model_write(h, x, y, z);
         end
      end
   endtask

   // Both channels valid in the same cycle; the winner gets ready in cycle 2,
   // the loser four cycles later.
   task automatic contend(input int lx, input int ly, input int lz,
                          input int rx, input int ry, input int rz,
                          input bit right_first);
      int l_cyc = right_first ? 6 : 2;
      int r_cyc = right_first ? 2 : 6;
      l_x = 16'(lx); l_y = 16'(ly); l_z = 16'(lz); l_valid = 1'b1;
      r_x = 16'(rx); r_y = 16'(ry); r_z = 16'(rz); r_valid = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge vclock);
         check($sformatf("contend.l_ready.c%0d", c), 32'(l_ready), 32'(c == l_cyc));
         check($sformatf("contend.r_ready.c%0d", c), 32'(r_ready), 32'(c == r_cyc));
         tick();
         if (c == l_cyc) l_valid = 1'b0;
         if (c == r_cyc) r_valid = 1'b0;
      end
      if (right_first) begin
         model_write(1, rx, ry, rz);
         model_write(0, lx, ly, lz);
      end else begin
         model_write(0, lx, ly, lz);
         model_write(1, rx, ry, rz);
      end
   endtask

   initial begin
      bit got;
      l_x = '0; l_y = '0; l_z = '0; r_x = '0; r_y = '0; r_z = '0;
      model_reset();

      // Reset state and first empty commit.
      do_reset();
      check("reset.l_ready", 32'(l_ready), 0);
      check("reset.r_ready", 32'(r_ready), 0);
      check("reset.fc", 32'(frame_commit), 0);
      check_all("reset");
      commit("empty");
      check("empty.x1_const", 32'(x1_disp), 0);

      // Single left update.
      send(0, 200, 300, 50, 0);
      commit("single");
      check("single.x1_const", 32'(x1_disp), 512);
      check("single.y1_const", 32'(y1_disp), 384);
      check("single.z1_const", 32'(z1_disp), 50);
      check("single.p1_const", 32'(present1), 1);
      check("single.p2_const", 32'(present2), 0);

      // Contention after reset: left wins first.
      do_reset();
      contend(10, 20, 30, 300, 500, 100, 0);
      commit("contend");
      check("contend.x2_const", 32'(x2_disp), 768);
      check("contend.y2_const", 32'(y2_disp), 640);
      check("contend.z2_const", 32'(z2_disp), 100);

      // Left granted last, so the next tie goes to the right.
      send(0, 40, 40, 4, 0);
      contend(111, 222, 333, 123, 456, 789, 1);
      commit("rr");

      // Clamping.
      send(0, 1000, 700, 7, 0);
      commit("clamp");
      check("clamp.x1_const", 32'(x1_disp), 1022);
      check("clamp.y1_const", 32'(y1_disp), 767);

      // Staleness: present1 falls exactly on the 8th empty commit.
      for (int k = 1; k <= 8; k++) begin
         commit($sformatf("stale%0d", k));
         check($sformatf("stale%0d.p1_const", k), 32'(present1), 32'(k < 8));
         check($sformatf("stale%0d.x1_kept", k), 32'(x1_disp), 1022);
      end

      // WRITE coinciding with vsync fall: old value now, new value next.
      send(0, 100, 100, 1, 1);
      check("collide.x1_old", 32'(x1_disp), 1022);
      commit("collide_next");
      check("collide_next.x1_const", 32'(x1_disp), 256);
      check("collide_next.y1_const", 32'(y1_disp), 128);

      // Reset during SCALE discards the sample.
      l_x = 16'd50; l_y = 16'd60; l_z = 16'd70; l_valid = 1'b1;
      got = 0;
      for (int c = 1; c <= 8 && !got; c++) begin
         @(negedge vclock);
         if (l_ready) got = 1;
         tick();
      end
      check("abort.got_ready", 32'(got), 1);
      l_valid = 1'b0;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      model_reset();
      commit("abort");
      send(0, 50, 60, 70, 0);
      commit("abort_resend");

      // Random frames.
      for (int f = 0; f < 30; f++) begin
         int ns = $urandom_range(0, 3);
         for (int s = 0; s < ns; s++) begin
            send($urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(0, 1023),
                 $urandom_range(0, 65535), ($urandom_range(0, 4) == 0));
         end
         commit($sformatf("rand%0d", f));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
